// File: rtl/adv_timer_pkg.sv
// adv_timer_pkg
// Shared definitions for the user-domain advanced timer subordinate:
// register word offsets (addr[11:2]), CTRL bit positions, the stored CTRL
// register layout and a byte-enable merge helper.
package adv_timer_pkg;

  typedef logic [31:0] word_t;

  // Word offsets inside the 4 KiB window (byte offset >> 2)
  localparam logic [9:0] OFF_CTRL     = 10'd0;
  localparam logic [9:0] OFF_PRESCALE = 10'd1;
  localparam logic [9:0] OFF_COUNT    = 10'd2;
  localparam logic [9:0] OFF_COMPARE  = 10'd3;
  localparam logic [9:0] OFF_STATUS   = 10'd4;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_ONESHOT_BIT = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 2;
  localparam int unsigned CTRL_CLR_BIT     = 3;

  localparam word_t COMPARE_RST = 32'hFFFF_FFFF;

  // Stored CTRL state; CLR is a strobe and is not held
  typedef struct packed {
    logic irq_en;
    logic oneshot;
    logic en;
  } ctrl_reg_t;

  // Replace only the bytes whose enable is set
  function automatic word_t be_merge(word_t old_val, word_t new_val, logic [3:0] be);
    word_t res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/adv_timer_core.sv
// adv_timer_core
// Prescaler, 32-bit counter, compare and one-shot logic of the advanced timer.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   en, oneshot    current CTRL values
//   prescale       current PRESCALE value
//   compare        current COMPARE value
//   clr            CTRL.CLR write strobe (zeroes count and prescaler)
//   prescale_we    any PRESCALE write (restarts the prescaler)
//   count_we       COUNT write strobe, count_wdata = byte-merged new value
//   count          current counter value
//   match_set      counter hit COMPARE on a tick this cycle
//   en_clr         one-shot request to drop CTRL.EN this cycle
module adv_timer_core
  import adv_timer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en,
  input  logic        oneshot,
  input  logic [15:0] prescale,
  input  word_t       compare,
  input  logic        clr,
  input  logic        prescale_we,
  input  logic        count_we,
  input  word_t       count_wdata,
  output word_t       count,
  output logic        match_set,
  output logic        en_clr
);

  logic [15:0] pre_cnt_r;
  word_t       count_r;
  logic        tick_s;
  logic        hit_s;

  // Tick and compare-hit decode from the pre-edge register values
  always_comb begin
    tick_s = en & (pre_cnt_r == prescale);
    hit_s  = tick_s & (count_r == compare);
  end

  assign count     = count_r;
  assign match_set = hit_s;
  assign en_clr    = hit_s & oneshot;

  // Prescaler: 0..PRESCALE while enabled, parked at 0 otherwise
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_cnt_r <= 16'd0;
    end else if (clr || prescale_we) begin
      pre_cnt_r <= 16'd0;
    end else if (!en || tick_s) begin
      pre_cnt_r <= 16'd0;
    end else begin
      pre_cnt_r <= pre_cnt_r + 16'd1;
    end
  end

  // Counter: software clear/write take priority over the tick update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_r <= 32'd0;
    end else if (clr) begin
      count_r <= 32'd0;
    end else if (count_we) begin
      count_r <= count_wdata;
    end else if (hit_s) begin
      count_r <= 32'd0;
    end else if (tick_s) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/user_adv_timer_obi_sbr.sv
// user_adv_timer_obi_sbr
// OBI subordinate for the user-domain advanced timer window. Always grants,
// answers one cycle after acceptance and exposes CTRL/PRESCALE/COUNT/
// COMPARE/STATUS plus a level interrupt.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_i/gnt_o                  request handshake (gnt_o tied high)
//   addr_i, we_i, be_i, wdata_i  request payload; addr_i[11:2] decoded
//   aid_i                        request ID, echoed on rid_o
//   rvalid_o, rdata_o, rid_o     response, one cycle after acceptance
//   err_o                        response error for unmapped offsets
//   irq_o                        registered MATCH & IRQ_EN
module user_adv_timer_obi_sbr
  import adv_timer_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [IdWidth-1:0]   aid_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic [IdWidth-1:0]   rid_o,
  output logic                 err_o,
  output logic                 irq_o
);

  logic [9:0]   word_idx_s;
  logic         wr_s;
  logic         ctrl_wr_s;
  logic         clr_s;
  logic         presc_wr_s;
  logic         count_wr_s;
  logic         cmp_wr_s;
  logic         status_w1c_s;
  logic         match_set_s;
  logic         en_clr_s;
  word_t        count_s;
  word_t        count_wdata_s;
  word_t        rdata_s;
  logic         err_s;
  ctrl_reg_t    ctrl_next_s;
  logic         match_next_s;

  ctrl_reg_t    ctrl_r;
  logic [15:0]  prescale_r;
  word_t        compare_r;
  logic         match_r;
  logic         irq_r;
  logic         rvalid_r;
  logic [IdWidth-1:0] rid_r;
  word_t        rdata_r;
  logic         err_r;

  logic         unused_addr_s;
  assign unused_addr_s = ^{addr_i[AddrWidth-1:12], addr_i[1:0]};

  assign gnt_o      = 1'b1;
  assign word_idx_s = addr_i[11:2];

  // Write strobes, one per register; CTRL and STATUS fields live in byte 0
  always_comb begin
    wr_s          = req_i & we_i;
    ctrl_wr_s     = wr_s & (word_idx_s == OFF_CTRL) & be_i[0];
    clr_s         = ctrl_wr_s & wdata_i[CTRL_CLR_BIT];
    presc_wr_s    = wr_s & (word_idx_s == OFF_PRESCALE);
    count_wr_s    = wr_s & (word_idx_s == OFF_COUNT);
    cmp_wr_s      = wr_s & (word_idx_s == OFF_COMPARE);
    status_w1c_s  = wr_s & (word_idx_s == OFF_STATUS) & be_i[0] & wdata_i[0];
    count_wdata_s = be_merge(count_s, wdata_i, be_i);
  end

  adv_timer_core u_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en          (ctrl_r.en),
    .oneshot     (ctrl_r.oneshot),
    .prescale    (prescale_r),
    .compare     (compare_r),
    .clr         (clr_s),
    .prescale_we (presc_wr_s),
    .count_we    (count_wr_s),
    .count_wdata (count_wdata_s),
    .count       (count_s),
    .match_set   (match_set_s),
    .en_clr      (en_clr_s)
  );

  // CTRL next value: a software write beats the one-shot auto-clear
  always_comb begin
    ctrl_next_s = ctrl_r;
    if (ctrl_wr_s) begin
      ctrl_next_s.en      = wdata_i[CTRL_EN_BIT];
      ctrl_next_s.oneshot = wdata_i[CTRL_ONESHOT_BIT];
      ctrl_next_s.irq_en  = wdata_i[CTRL_IRQ_EN_BIT];
    end else if (en_clr_s) begin
      ctrl_next_s.en = 1'b0;
    end else begin
      ctrl_next_s = ctrl_r;
    end
  end

  // MATCH next value: a hardware set beats a same-cycle W1C
  always_comb begin
    if (match_set_s) begin
      match_next_s = 1'b1;
    end else if (status_w1c_s) begin
      match_next_s = 1'b0;
    end else begin
      match_next_s = match_r;
    end
  end

  // Read mux and unmapped-offset detection
  always_comb begin
    rdata_s = 32'h0000_0000;
    err_s   = 1'b0;
    case (word_idx_s)
      OFF_CTRL:     rdata_s = {29'd0, ctrl_r.irq_en, ctrl_r.oneshot, ctrl_r.en};
      OFF_PRESCALE: rdata_s = {16'd0, prescale_r};
      OFF_COUNT:    rdata_s = count_s;
      OFF_COMPARE:  rdata_s = compare_r;
      OFF_STATUS:   rdata_s = {31'd0, match_r};
      default:      err_s   = 1'b1;
    endcase
  end

  // Register file and interrupt register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_r     <= ctrl_reg_t'(3'b000);
      prescale_r <= 16'd0;
      compare_r  <= COMPARE_RST;
      match_r    <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      ctrl_r  <= ctrl_next_s;
      match_r <= match_next_s;
      irq_r   <= match_next_s & ctrl_next_s.irq_en;
      if (cmp_wr_s) begin
        compare_r <= be_merge(compare_r, wdata_i, be_i);
      end
      if (presc_wr_s && be_i[0]) begin
        prescale_r[7:0] <= wdata_i[7:0];
      end
      if (presc_wr_s && be_i[1]) begin
        prescale_r[15:8] <= wdata_i[15:8];
      end
    end
  end

  // Response pipeline: one cycle after acceptance, dropped on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_r <= 1'b0;
      rid_r    <= {IdWidth{1'b0}};
      rdata_r  <= 32'h0000_0000;
      err_r    <= 1'b0;
    end else begin
      rvalid_r <= req_i;
      rid_r    <= req_i ? aid_i : rid_r;
      err_r    <= req_i & err_s;
      rdata_r  <= (req_i && !we_i) ? rdata_s : 32'h0000_0000;
    end
  end

  assign rvalid_o = rvalid_r;
  assign rid_o    = rid_r;
  assign rdata_o  = rdata_r;
  assign err_o    = err_r;
  assign irq_o    = irq_r;

endmodule

// File: tb/tb_user_adv_timer_obi_sbr.sv
// Self-checking bench for user_adv_timer_obi_sbr: a cycle-level behavioural
// model of the timer is compared against the DUT every cycle, and directed
// scenarios pin the model with hand-computed literal values.
module tb_user_adv_timer_obi_sbr;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [0:0]  aid;
  logic        gnt, rvalid, err, irq;
  logic [31:0] rdata;
  logic [0:0]  rid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  user_adv_timer_obi_sbr dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .aid_i(aid), .rvalid_o(rvalid),
    .rdata_o(rdata), .rid_o(rid), .err_o(err), .irq_o(irq)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          en, oneshot, irqen, match, irq;
    int unsigned pre;
    bit [15:0]   presc;
    bit [31:0]   count, compare;
    bit          rvalid, err;
    bit [0:0]    rid;
    bit [31:0]   rdata;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t reset_state();
    mstate_t s;
    s.en = 0; s.oneshot = 0; s.irqen = 0; s.match = 0; s.irq = 0;
    s.pre = 0; s.presc = 16'd0; s.count = 32'd0; s.compare = 32'hFFFF_FFFF;
    s.rvalid = 0; s.err = 0; s.rid = 1'b0; s.rdata = 32'd0;
    return s;
  endfunction

  function automatic bit [31:0] merge(bit [31:0] old_v, bit [31:0] new_v, bit [3:0] b);
    bit [31:0] v = old_v;
    for (int i = 0; i < 4; i++) if (b[i]) v[8*i +: 8] = new_v[8*i +: 8];
    return v;
  endfunction

  function automatic bit [31:0] regval(mstate_t s, int unsigned w);
    case (w)
      0: return {29'd0, s.irqen, s.oneshot, s.en};
      1: return {16'd0, s.presc};
      2: return s.count;
      3: return s.compare;
      4: return {31'd0, s.match};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the timer as described by its rules
  function automatic mstate_t step(mstate_t s, bit rq, bit w_e, bit [3:0] b,
                                   bit [31:0] a, bit [31:0] wd, bit [0:0] id);
    mstate_t n = s;
    int unsigned w = int'(a[11:2]);
    bit tick = s.en && (s.pre == int'(s.presc));
    bit hit  = tick && (s.count == s.compare);
    bit [31:0] tmp;
    if (tick) begin
      if (hit) begin
        n.count = 0; n.match = 1;
        if (s.oneshot) n.en = 0;
      end else n.count = s.count + 1;
    end
    n.pre = (!s.en || tick) ? 0 : s.pre + 1;
    n.rvalid = rq; n.err = 0; n.rdata = 0;
    if (rq) n.rid = id;
    if (rq) begin
      if (w > 4) n.err = 1;
      else if (!w_e) n.rdata = regval(s, w);
      else begin
        case (w)
          0: if (b[0]) begin
               n.en = wd[0]; n.oneshot = wd[1]; n.irqen = wd[2];
               if (wd[3]) begin n.count = 0; n.pre = 0; end
             end
          1: begin tmp = merge({16'd0, s.presc}, wd, b); n.presc = tmp[15:0]; n.pre = 0; end
          2: n.count = merge(s.count, wd, b);
          3: n.compare = merge(s.compare, wd, b);
          4: if (b[0] && wd[0] && !hit) n.match = 0;
          default: ;
        endcase
      end
    end
    n.irq = n.match && n.irqen;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= reset_state();
    else     m <= step(m, req, we, be, addr, wdata, aid);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("gnt", 32'(gnt), 32'd1);
      check("rvalid", 32'(rvalid), 32'(m.rvalid));
      check("irq", 32'(irq), 32'(m.irq));
      if (m.rvalid) begin
        check("rid", 32'(rid), 32'(m.rid));
        check("err", 32'(err), 32'(m.err));
        check("rdata", rdata, m.rdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1; we = 1; addr = a; wdata = d; be = b; aid = ~aid;
    @(posedge clk); #1 req = 0; we = 0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    req = 1; we = 0; addr = a; wdata = 32'd0; be = 4'hF; aid = ~aid;
    @(posedge clk); #1 req = 0;
    @(negedge clk);
    check("rd_rvalid_lat", 32'(rvalid), 32'd1);
    d = rdata; e = err;
  endtask

  task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    rd(a, d, e);
    check(name, d, exp);
    check({name, "_err"}, 32'(e), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic e;
    rst = 1; req = 0; we = 0; addr = 0; wdata = 0; be = 0; aid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 0;

    // reset values
    rdchk("rst_ctrl", 32'h00, 32'h0);
    rdchk("rst_presc", 32'h04, 32'h0);
    rdchk("rst_count", 32'h08, 32'h0);
    rdchk("rst_cmp", 32'h0C, 32'hFFFF_FFFF);
    rdchk("rst_status", 32'h10, 32'h0);

    // byte enables
    wr(32'h0C, 32'hAABB_CCDD, 4'b0010);
    rdchk("be_cmp", 32'h0C, 32'hFFFF_CCFF);

    // prescaled periodic match with interrupt; CTRL write is edge E0
    wr(32'h04, 32'd3, 4'hF);
    wr(32'h0C, 32'd4, 4'hF);
    wr(32'h00, 32'h5, 4'hF);
    repeat (4) @(negedge clk);
    rdchk("pre_count1", 32'h08, 32'd1);
    repeat (10) @(negedge clk);
    rdchk("pre_count3", 32'h08, 32'd3);
    rdchk("pre_status0", 32'h10, 32'd0);
    repeat (2) @(negedge clk);
    check("pre_irq_before", 32'(irq), 32'd0);
    rdchk("pre_count4", 32'h08, 32'd4);
    rdchk("pre_count_wrap", 32'h08, 32'd0);
    check("pre_irq_set", 32'(irq), 32'd1);
    rdchk("pre_status1", 32'h10, 32'd1);
    wr(32'h10, 32'd1, 4'hF);
    check("pre_irq_clr", 32'(irq), 32'd0);
    rdchk("pre_status_clr", 32'h10, 32'd0);
    rdchk("pre_presc", 32'h04, 32'd3);
    wr(32'h00, 32'h0, 4'hF);

    // W1C in the same cycle as a match
    wr(32'h04, 32'd0, 4'hF);
    wr(32'h0C, 32'd3, 4'hF);
    wr(32'h00, 32'h8, 4'hF);
    wr(32'h00, 32'h1, 4'hF);
    repeat (3) @(negedge clk);
    wr(32'h10, 32'd1, 4'hF);
    rdchk("col_match_kept", 32'h10, 32'd1);
    wr(32'h00, 32'h0, 4'hF);
    wr(32'h10, 32'd1, 4'hF);
    rdchk("col_match_clr", 32'h10, 32'd0);

    // COUNT write on a tick
    wr(32'h0C, 32'hFFFF_FFFF, 4'hF);
    wr(32'h00, 32'h8, 4'hF);
    wr(32'h00, 32'h1, 4'hF);
    wr(32'h08, 32'd7, 4'hF);
    rdchk("col_count7", 32'h08, 32'd7);
    rdchk("col_count8", 32'h08, 32'd8);
    wr(32'h00, 32'h0, 4'hF);

    // one-shot
    wr(32'h00, 32'h8, 4'hF);
    wr(32'h10, 32'd1, 4'hF);
    wr(32'h04, 32'd0, 4'hF);
    wr(32'h0C, 32'd2, 4'hF);
    wr(32'h00, 32'h3, 4'hF);
    repeat (3) @(negedge clk);
    rdchk("os_status", 32'h10, 32'd1);
    rdchk("os_ctrl", 32'h00, 32'h2);
    rdchk("os_count", 32'h08, 32'd0);

    // unmapped offset
    rd(32'h40, d, e);
    check("err_flag", 32'(e), 32'd1);
    check("err_rdata", d, 32'd0);
    wr(32'h40, 32'hFFFF_FFFF, 4'hF);
    rdchk("err_ctrl", 32'h00, 32'h2);
    rdchk("err_presc", 32'h04, 32'd0);
    rdchk("err_count", 32'h08, 32'd0);
    rdchk("err_cmp", 32'h0C, 32'd2);
    rdchk("err_status", 32'h10, 32'd1);

    // reset mid-operation with a response in flight
    wr(32'h10, 32'd1, 4'hF);
    wr(32'h0C, 32'd1, 4'hF);
    wr(32'h00, 32'h8, 4'hF);
    wr(32'h00, 32'h5, 4'hF);
    repeat (4) @(negedge clk);
    check("rst_pre_irq", 32'(irq), 32'd1);
    req = 1; we = 0; addr = 32'h08; be = 4'hF; aid = 1'b1;
    @(posedge clk); #1 req = 0;
    #1 rst = 1;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_rid", 32'(rid), 32'd0);
    @(negedge clk);
    rst = 0;
    rdchk("post_rst_count", 32'h08, 32'd0);
    rdchk("post_rst_ctrl", 32'h00, 32'd0);
    rdchk("post_rst_cmp", 32'h0C, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
